// File: rtl/hamming_pkg.sv
// hamming_pkg: shared checker state encodings and (7,4) codeword bit positions
package hamming_pkg;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    S1      = 3'd1,
    S2      = 3'd2,
    S4      = 3'd3,
    CORRECT = 3'd4,
    DONE    = 3'd5
  } state_t;
  localparam int P1 = 0;
  localparam int P2 = 1;
  localparam int D0 = 2;
  localparam int P4 = 3;
  localparam int D1 = 4;
  localparam int D2 = 5;
  localparam int D3 = 6;
endpackage

// File: rtl/hamming_checker.sv
// hamming_checker: serial (7,4) Hamming syndrome check with single-bit correction and error count
module hamming_checker
  import hamming_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       code_in,
  input  logic             enable,
  input  logic             mode,
  input  logic             clr_count,
  output logic             busy,
  output logic             valid,
  output logic [3:0]       data_out,
  output logic [2:0]       syndrome,
  output logic             err_corrected,
  output logic [CNT_W-1:0] err_count
);
  state_t state, nxt;
  logic [6:0] code_r;
  logic       mode_r;
  logic [2:0] s_r;
  logic [6:0] flip;
  logic [6:0] fixed;
  logic       inc;
  assign flip  = (s_r == 3'd0) ? 7'd0 : 7'd1 << (s_r - 3'd1);
  assign fixed = code_r ^ flip;
  assign inc   = (state == CORRECT) && (s_r != 3'd0) && !(&err_count);
  assign busy  = state != IDLE;
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:    nxt = enable ? S1 : IDLE;
      S1:      nxt = S2;
      S2:      nxt = S4;
      S4:      nxt = CORRECT;
      CORRECT: nxt = DONE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_r        <= '0;
      mode_r        <= 1'b0;
      s_r           <= '0;
      valid         <= 1'b0;
      data_out      <= '0;
      syndrome      <= '0;
      err_corrected <= 1'b0;
      err_count     <= '0;
    end else begin
      valid <= state == CORRECT;
      if (clr_count) err_count <= '0;
      else if (inc)  err_count <= err_count + {{(CNT_W-1){1'b0}}, 1'b1};
      case (state)
        IDLE: if (enable) begin
          code_r <= code_in;
          mode_r <= mode;
        end
        S1: s_r[0] <= code_r[P1] ^ code_r[D0] ^ code_r[D1] ^ code_r[D3] ^ ~mode_r;
        S2: s_r[1] <= code_r[P2] ^ code_r[D0] ^ code_r[D2] ^ code_r[D3] ^ ~mode_r;
        S4: s_r[2] <= code_r[P4] ^ code_r[D1] ^ code_r[D2] ^ code_r[D3] ^ ~mode_r;
        CORRECT: begin
          code_r        <= fixed;
          data_out      <= {fixed[D3], fixed[D2], fixed[D1], fixed[D0]};
          syndrome      <= s_r;
          err_corrected <= s_r != 3'd0;
        end
        DONE: ;
        default: s_r <= '0;
      endcase
    end
  end
endmodule

// File: tb/tb_hamming_checker.sv
// tb_hamming_checker: directed table-driven checks of the serial Hamming checker
module tb_hamming_checker;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] code_in = '0;
  logic       enable = 1'b0;
  logic       mode = 1'b0;
  logic       clr_count = 1'b0;
  logic       busy, valid, err_corrected;
  logic [3:0] data_out;
  logic [2:0] syndrome;
  logic [7:0] err_count;
  logic       busy2, valid2, err2;
  logic [3:0] data2;
  logic [2:0] syn2;
  logic [1:0] cnt2;
  int checks = 0;
  int failures = 0;
  int exp_cnt = 0;
  int exp_small = 0;
  typedef struct {
    logic [6:0] code;
    logic       mode;
    logic [3:0] data;
    logic [2:0] syn;
  } vec_t;
  vec_t vecs[14];
  logic [6:0] words[4] = '{7'h55, 7'h00, 7'h7F, 7'h07};
  logic [3:0] wdata[4] = '{4'hB, 4'h0, 4'hF, 4'h1};
  hamming_checker #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .code_in(code_in), .enable(enable), .mode(mode),
    .clr_count(clr_count), .busy(busy), .valid(valid), .data_out(data_out),
    .syndrome(syndrome), .err_corrected(err_corrected), .err_count(err_count)
  );
  hamming_checker #(.CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .code_in(code_in), .enable(enable), .mode(mode),
    .clr_count(clr_count), .busy(busy2), .valid(valid2), .data_out(data2),
    .syndrome(syn2), .err_corrected(err2), .err_count(cnt2)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic bump(input logic [2:0] syn);
    if (syn != 3'd0) begin
      exp_cnt   = (exp_cnt == 255) ? 255 : exp_cnt + 1;
      exp_small = (exp_small == 3) ? 3 : exp_small + 1;
    end
  endtask
  task automatic decode(input logic [6:0] code, input logic md,
                        input logic [3:0] exp_data, input logic [2:0] exp_syn);
    int n;
    code_in = code;
    mode    = md;
    enable  = 1'b1;
    tick();
    enable  = 1'b0;
    code_in = ~code;
    mode    = ~md;
    chk("busy_after_start", busy, 1);
    n = 0;
    while (n < 10) begin
      tick();
      n++;
      if (valid) break;
    end
    bump(exp_syn);
    chk("latency", n, 4);
    chk("data_out", data_out, exp_data);
    chk("syndrome", syndrome, exp_syn);
    chk("err_corrected", err_corrected, exp_syn != 3'd0);
    chk("err_count", err_count, exp_cnt);
    chk("err_count_small", cnt2, exp_small);
    tick();
    chk("valid_drop", valid, 0);
    chk("busy_drop", busy, 0);
  endtask
  initial begin
    int nvalid;
    vecs[0]  = '{7'h55, 1'b1, 4'hB, 3'd0};
    vecs[1]  = '{7'h45, 1'b1, 4'hB, 3'd5};
    vecs[2]  = '{7'h5E, 1'b0, 4'hB, 3'd0};
    vecs[3]  = '{7'h5C, 1'b0, 4'hB, 3'd2};
    vecs[4]  = '{7'h54, 1'b1, 4'hB, 3'd1};
    vecs[5]  = '{7'h57, 1'b1, 4'hB, 3'd2};
    vecs[6]  = '{7'h51, 1'b1, 4'hB, 3'd3};
    vecs[7]  = '{7'h5D, 1'b1, 4'hB, 3'd4};
    vecs[8]  = '{7'h75, 1'b1, 4'hB, 3'd6};
    vecs[9]  = '{7'h15, 1'b1, 4'hB, 3'd7};
    vecs[10] = '{7'h0B, 1'b0, 4'h0, 3'd0};
    vecs[11] = '{7'h7F, 1'b1, 4'hF, 3'd0};
    vecs[12] = '{7'h7F, 1'b0, 4'h7, 3'd7};
    vecs[13] = '{7'h56, 1'b1, 4'hA, 3'd3};
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_data", data_out, 0);
    chk("rst_syndrome", syndrome, 0);
    chk("rst_err_corrected", err_corrected, 0);
    chk("rst_err_count", err_count, 0);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 14; i++) decode(vecs[i].code, vecs[i].mode, vecs[i].data, vecs[i].syn);
    code_in = 7'h55;
    mode    = 1'b1;
    enable  = 1'b1;
    tick();
    enable  = 1'b0;
    tick();
    @(posedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_valid", valid, 0);
    chk("abort_data", data_out, 0);
    chk("abort_syndrome", syndrome, 0);
    chk("abort_err_corrected", err_corrected, 0);
    chk("abort_err_count", err_count, 0);
    exp_cnt   = 0;
    exp_small = 0;
    tick();
    rst = 1'b0;
    nvalid = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (valid) nvalid++;
    end
    chk("abort_no_valid", nvalid, 0);
    decode(7'h45, 1'b1, 4'hB, 3'd5);
    nvalid = 0;
    mode   = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 26; i++) begin
      code_in = words[i % 4];
      tick();
      if (valid) begin
        nvalid++;
        chk("hold_spacing", i % 6, 4);
        chk("hold_data", data_out, wdata[(i - 4) % 4]);
      end
    end
    enable = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("hold_valid_count", nvalid, 4);
    chk("hold_err_count", err_count, exp_cnt);
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    exp_cnt   = 0;
    exp_small = 0;
    chk("clr_idle", err_count, 0);
    chk("clr_idle_small", cnt2, 0);
    for (int i = 0; i < 4; i++) decode(vecs[4 + i].code, 1'b1, 4'hB, vecs[4 + i].syn);
    chk("sat_small", cnt2, 3);
    chk("count_main", err_count, 4);
    code_in = 7'h45;
    mode    = 1'b1;
    enable  = 1'b1;
    tick();
    enable  = 1'b0;
    tick();
    tick();
    tick();
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    chk("clr_wins_valid", valid, 1);
    chk("clr_wins_syndrome", syndrome, 5);
    chk("clr_wins_count", err_count, 0);
    chk("clr_wins_small", cnt2, 0);
    tick();
    chk("clr_wins_done", busy, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
